ps2_key_cmd: RTL and testbench

Converts the PS/2 keyboard receiver's decoded key events into buffered game commands for the PushBox game controller. It sits directly downstream of the PS/2 receiver and consumes its 10-bit `{expand, break, code}` word and one-cycle `ready` strobe. It tracks which command keys are held, suppresses keyboard typematic repeats, and queues one command per physical press in a small FIFO with a valid/ready handshake toward the game logic.

---
 rtl/ps2_key_cmd_pkg.sv | 44 ++++
 rtl/ps2_key_cmd_fifo.sv | 46 ++++
 rtl/ps2_key_cmd.sv | 108 ++++++++++
 tb/tb_ps2_key_cmd.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_cmd_pkg.sv
// ps2_key_cmd_pkg: command codes, scan codes and key_data layout shared by ps2_key_cmd.
package ps2_key_cmd_pkg;
  localparam logic [2:0] CMD_UP      = 3'd0;
  localparam logic [2:0] CMD_DOWN    = 3'd1;
  localparam logic [2:0] CMD_LEFT    = 3'd2;
  localparam logic [2:0] CMD_RIGHT   = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;
  localparam logic [2:0] CMD_NEXT    = 3'd5;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_R       = 8'h2D;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam int KEY_EXP_BIT = 9;
  localparam int KEY_BRK_BIT = 8;
  typedef struct packed {
    logic       hit;
    logic [2:0] cmd;
    logic       brk;
  } dec_t;
  function automatic dec_t key_decode(input logic [9:0] kd);
    dec_t r;
    r.brk = kd[KEY_BRK_BIT];
    r.hit = 1'b1;
    case ({kd[KEY_EXP_BIT], kd[7:0]})
      {1'b1, SC_E_UP},    {1'b0, SC_W}: r.cmd = CMD_UP;
      {1'b1, SC_E_DOWN},  {1'b0, SC_S}: r.cmd = CMD_DOWN;
      {1'b1, SC_E_LEFT},  {1'b0, SC_A}: r.cmd = CMD_LEFT;
      {1'b1, SC_E_RIGHT}, {1'b0, SC_D}: r.cmd = CMD_RIGHT;
      {1'b0, SC_R}:                     r.cmd = CMD_RESTART;
      {1'b0, SC_ENTER}:                 r.cmd = CMD_NEXT;
      default: begin
        r.hit = 1'b0;
        r.cmd = CMD_UP;
      end
    endcase
    return r;
  endfunction
endpackage

// File: rtl/ps2_key_cmd_fifo.sv
// cmd_fifo: power-of-two FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_key_cmd.sv
// ps2_key_cmd: PS/2 key events to queued PushBox commands with held tracking and typematic suppression.
// Define PS2_KEY_CMD_AUTOREPEAT_EN to add timed auto-repeat of direction commands.
module ps2_key_cmd
  import ps2_key_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_data,
  input  logic       key_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [5:0] held,
  output logic       overflow
);
  dec_t dec_q, dec_d;
  logic [5:0] held_q, held_d;
  logic ovf_q, ovf_d;
  logic key_push, push, pop, full, empty;
  logic [2:0] push_cmd;
  assign cmd_valid = ~empty;
  assign pop       = ~empty & cmd_ready;
  assign held      = held_q;
  assign overflow  = ovf_q;
  always_comb begin
    dec_d    = key_valid ? key_decode(key_data) : '0;
    held_d   = held_q;
    key_push = 1'b0;
    if (dec_q.hit) begin
      if (dec_q.brk) held_d[dec_q.cmd] = 1'b0;
      else if (!held_q[dec_q.cmd]) begin
        held_d[dec_q.cmd] = 1'b1;
        key_push          = 1'b1;
      end
    end
    ovf_d = ovf_q | (push & full & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q  <= '0;
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      dec_q  <= dec_d;
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end
`ifdef PS2_KEY_CMD_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_t;
  rpt_t rpt_q, rpt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0] rcmd_q, rcmd_d;
  logic rep_push;
  always_comb begin
    rpt_d    = rpt_q;
    rcnt_d   = rcnt_q;
    rcmd_d   = rcmd_q;
    rep_push = 1'b0;
    if (key_push && !dec_q.cmd[2]) begin
      rpt_d  = RPT_DELAY;
      rcnt_d = RW'(REPEAT_DELAY - 1);
      rcmd_d = dec_q.cmd[1:0];
    end else if (rpt_q != RPT_IDLE && dec_q.hit && dec_q.brk && dec_q.cmd == {1'b0, rcmd_q}) begin
      rpt_d = RPT_IDLE;
    end else if (rpt_q != RPT_IDLE) begin
      // a same-cycle key push takes the FIFO slot; this repeat tick is skipped
      if (rcnt_q == '0) begin
        rep_push = ~key_push;
        rpt_d    = RPT_REPEAT;
        rcnt_d   = RW'(REPEAT_PERIOD - 1);
      end else rcnt_d = rcnt_q - RW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q  <= RPT_IDLE;
      rcnt_q <= '0;
      rcmd_q <= '0;
    end else begin
      rpt_q  <= rpt_d;
      rcnt_q <= rcnt_d;
      rcmd_q <= rcmd_d;
    end
  end
  assign push     = key_push | rep_push;
  assign push_cmd = key_push ? dec_q.cmd : {1'b0, rcmd_q};
`else
  assign push     = key_push;
  assign push_cmd = dec_q.cmd;
`endif
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_cmd),
    .dout (cmd),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_key_cmd.sv
// tb_ps2_key_cmd: vector table plus scoreboard of expected commands for ps2_key_cmd.
module tb_ps2_key_cmd;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, cmd_ready = 1'b0;
  logic [9:0] key_data = '0;
  logic [2:0] cmd;
  logic cmd_valid, overflow;
  logic [5:0] held;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [2:0] c; int at;} exp_t;
  typedef struct {logic [9:0] kd; bit push; logic [2:0] c; logic [5:0] held;} vec_t;
  exp_t sb[$];
  vec_t vt[18];
`ifdef PS2_KEY_CMD_AUTOREPEAT_EN
  localparam int RD = 20, RP = 8;
`else
  localparam int RD = 25_000_000, RP = 10_000_000;
`endif
  ps2_key_cmd #(.FIFO_DEPTH(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_data(key_data), .key_valid(key_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .held(held), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic strobe(input logic [9:0] kd);
    key_data  = kd;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask
  task automatic expect_cmd(input logic [2:0] c, input int at);
    sb.push_back(exp_t'{c, at});
  endtask
  task automatic drain();
    step();
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    cmd_ready = 1'b0;
    smp();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_cmd_valid", cmd_valid, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %0d expected none (cycle %0d)", cmd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_cmd", cmd, e.c);
        if (e.at >= 0) chk("pop_cycle", cyc, e.at);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{10'h275, 1'b1, 3'd0, 6'b000001};
    vt[1]  = '{10'h375, 1'b0, 3'd0, 6'b000000};
    vt[2]  = '{10'h01D, 1'b1, 3'd0, 6'b000001};
    vt[3]  = '{10'h01D, 1'b0, 3'd0, 6'b000001};
    vt[4]  = '{10'h01D, 1'b0, 3'd0, 6'b000001};
    vt[5]  = '{10'h11D, 1'b0, 3'd0, 6'b000000};
    vt[6]  = '{10'h015, 1'b0, 3'd0, 6'b000000};
    vt[7]  = '{10'h21D, 1'b0, 3'd0, 6'b000000};
    vt[8]  = '{10'h01B, 1'b1, 3'd1, 6'b000010};
    vt[9]  = '{10'h272, 1'b0, 3'd0, 6'b000010};
    vt[10] = '{10'h372, 1'b0, 3'd0, 6'b000000};
    vt[11] = '{10'h26B, 1'b1, 3'd2, 6'b000100};
    vt[12] = '{10'h023, 1'b1, 3'd3, 6'b001100};
    vt[13] = '{10'h02D, 1'b1, 3'd4, 6'b011100};
    vt[14] = '{10'h05A, 1'b1, 3'd5, 6'b111100};
    vt[15] = '{10'h25A, 1'b0, 3'd0, 6'b111100};
    vt[16] = '{10'h11C, 1'b0, 3'd0, 6'b111000};
    vt[17] = '{10'h115, 1'b0, 3'd0, 6'b111000};
    repeat (3) step();
    rst = 1'b0;
    smp();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_held", held, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cmd", cmd, 0);
    // exact latency of the first command: visible two cycles after the strobe
    step();
    expect_cmd(3'd0, -1);
    strobe(10'h275);
    smp();
    chk("lat_valid_n1", cmd_valid, 0);
    step();
    smp();
    chk("lat_valid_n2", cmd_valid, 1);
    chk("lat_cmd_n2", cmd, 0);
    chk("lat_held_n2", held, 6'b000001);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    smp();
    chk("after_pop_valid", cmd_valid, 0);
    step();
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (vt[i].push) expect_cmd(vt[i].c, cyc + 2);
      strobe(vt[i].kd);
      step();
      smp();
      chk($sformatf("vec%0d_held", i), held, vt[i].held);
      step();
    end
    cmd_ready = 1'b0;
    smp();
    chk("table_overflow", overflow, 0);
    chk("table_sb_empty", sb.size(), 0);
    // fill past depth with consumer stalled
    step();
    do_reset();
    expect_cmd(3'd0, -1);
    expect_cmd(3'd1, -1);
    expect_cmd(3'd2, -1);
    expect_cmd(3'd3, -1);
    strobe(10'h275);
    strobe(10'h01B);
    strobe(10'h01C);
    strobe(10'h023);
    strobe(10'h02D);
    step();
    step();
    smp();
    chk("ovf_set", overflow, 1);
    chk("ovf_head", cmd, 0);
    chk("ovf_valid", cmd_valid, 1);
    chk("ovf_held", held, 6'b011111);
    // push and pop in the same cycle while full
    step();
    expect_cmd(3'd5, -1);
    strobe(10'h05A);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    smp();
    chk("pp_held", held, 6'b111111);
    chk("pp_head", cmd, 1);
    drain();
    chk("ovf_sticky", overflow, 1);
    // queue three entries then reset mid-operation
    step();
    strobe(10'h375);
    strobe(10'h11B);
    strobe(10'h11C);
    expect_cmd(3'd0, -1);
    expect_cmd(3'd1, -1);
    expect_cmd(3'd2, -1);
    strobe(10'h275);
    strobe(10'h01B);
    strobe(10'h26B);
    step();
    step();
    smp();
    chk("pre_rst_valid", cmd_valid, 1);
    chk("pre_rst_held", held, 6'b111111);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    smp();
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_held", held, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_cmd", cmd, 0);
`ifdef PS2_KEY_CMD_AUTOREPEAT_EN
    step();
    cmd_ready = 1'b1;
    step();
    begin
      int n;
      n = cyc;
      expect_cmd(3'd3, n + 2);
      expect_cmd(3'd3, n + 22);
      expect_cmd(3'd3, n + 30);
      expect_cmd(3'd3, n + 38);
      expect_cmd(3'd3, n + 46);
      strobe(10'h023);
      repeat (49) step();
      strobe(10'h123);
      repeat (20) step();
      smp();
      chk("ar_hold_sb_empty", sb.size(), 0);
      chk("ar_hold_held", held, 0);
      step();
      n = cyc;
      expect_cmd(3'd3, n + 2);
      expect_cmd(3'd2, n + 12);
      expect_cmd(3'd2, n + 32);
      strobe(10'h023);
      repeat (9) step();
      strobe(10'h01C);
      repeat (24) step();
      strobe(10'h11C);
      repeat (15) step();
      smp();
      chk("ar_retarget_sb_empty", sb.size(), 0);
      chk("ar_retarget_held", held, 6'b001000);
    end
    cmd_ready = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
